// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, constants and helpers for the FFT frame controller
package fft_pkg;

  typedef enum logic {
    SEND_CFG = 1'b0,
    STREAM   = 1'b1
  } state_e;

  localparam int ERR_TLAST_UNEXP = 0;
  localparam int ERR_TLAST_MISS  = 1;
  localparam int ERR_OUT_LEN     = 2;

  localparam int NFFT_LOG2_DEF = 9;
  localparam int FRAME_LEN     = 1 << NFFT_LOG2_DEF;

  function automatic int frame_len(input int nfft_log2);
    return 1 << nfft_log2;
  endfunction

  // Bit0 follows the core FWD_INV convention: 1 = forward.
  function automatic logic [31:0] build_cfg_word(input logic [31:0] scale, input logic inverse);
    return {scale[30:0], ~inverse};
  endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// rtl/fft_frame_ctrl_if.sv - control, stream and status signals of the FFT frame controller
interface fft_frame_ctrl_if #(
  parameter int DATAWIDTH   = 48,
  parameter int SCALE_WIDTH = 10,
  parameter int CFG_WIDTH   = 16
);
  logic                   inverse;
  logic [SCALE_WIDTH-1:0] scale_sch;
  logic                   err_clr;

  logic [DATAWIDTH-1:0]   s_in_tdata;
  logic                   s_in_tvalid;
  logic                   s_in_tready;

  logic [CFG_WIDTH-1:0]   m_cfg_tdata;
  logic                   m_cfg_tvalid;
  logic                   m_cfg_tready;

  logic [DATAWIDTH-1:0]   m_fft_tdata;
  logic                   m_fft_tvalid;
  logic                   m_fft_tready;
  logic                   m_fft_tlast;

  logic [DATAWIDTH-1:0]   s_fft_tdata;
  logic                   s_fft_tvalid;
  logic                   s_fft_tready;
  logic                   s_fft_tlast;

  logic                   ev_tlast_unexpected;
  logic                   ev_tlast_missing;

  logic [DATAWIDTH-1:0]   m_out_tdata;
  logic                   m_out_tvalid;
  logic                   m_out_tready;
  logic                   m_out_tlast;

  logic [15:0]            frame_cnt;
  logic [2:0]             err;

  modport master (
    input  inverse, scale_sch, err_clr,
    input  s_in_tdata, s_in_tvalid, output s_in_tready,
    output m_cfg_tdata, m_cfg_tvalid, input m_cfg_tready,
    output m_fft_tdata, m_fft_tvalid, m_fft_tlast, input m_fft_tready,
    input  s_fft_tdata, s_fft_tvalid, s_fft_tlast, output s_fft_tready,
    input  ev_tlast_unexpected, ev_tlast_missing,
    output m_out_tdata, m_out_tvalid, m_out_tlast, input m_out_tready,
    output frame_cnt, err
  );

  modport slave (
    output inverse, scale_sch, err_clr,
    output s_in_tdata, s_in_tvalid, input s_in_tready,
    input  m_cfg_tdata, m_cfg_tvalid, output m_cfg_tready,
    input  m_fft_tdata, m_fft_tvalid, m_fft_tlast, output m_fft_tready,
    output s_fft_tdata, s_fft_tvalid, s_fft_tlast, input s_fft_tready,
    output ev_tlast_unexpected, ev_tlast_missing,
    input  m_out_tdata, m_out_tvalid, m_out_tlast, output m_out_tready,
    input  frame_cnt, err
  );
endinterface

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - 2-entry registered stream buffer, full throughput, no comb ready path
module axis_skid_buf #(
  parameter int WIDTH = 49
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);
  logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign s_tready = (cnt_q != 2'd2);
  assign m_tvalid = (cnt_q != 2'd0);
  assign m_tdata  = d0_q;
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;

  // d0 is always the head; d1 only holds data while the consumer stalls.
  always_comb begin
    d0_d  = d0_q;
    d1_d  = d1_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) d0_d = s_tdata;
        else               d1_d = s_tdata;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        d0_d  = d1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) d0_d = s_tdata;
        else begin
          d0_d = d1_q;
          d1_d = s_tdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
    d0_q <= d0_d;
    d1_q <= d1_d;
  end
endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frames the sample stream into the FFT core and checks its output
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int DATAWIDTH   = 48,
  parameter int NFFT_LOG2   = 9,
  parameter int SCALE_WIDTH = 10,
  parameter int CFG_WIDTH   = 16
) (
  input logic              clk,
  input logic              resetn,
  fft_frame_ctrl_if.master bus
);
  localparam int                   FRAME_LEN_P = frame_len(NFFT_LOG2);
  localparam logic [NFFT_LOG2-1:0] LAST_IDX    = NFFT_LOG2'(FRAME_LEN_P - 1);

  state_e                 state_q, state_d;
  logic                   cfg_valid_q, cfg_valid_d;
  logic                   inverse_q, inverse_d;
  logic [SCALE_WIDTH-1:0] scale_q, scale_d;
  logic [NFFT_LOG2-1:0]   in_cnt_q, in_cnt_d;
  logic [NFFT_LOG2-1:0]   out_cnt_q, out_cnt_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [2:0]             err_q, err_d;

  logic                   streaming, in_fire, in_last, mode_changed;
  logic                   out_fire, len_err;
  logic [DATAWIDTH:0]     out_word;

  assign streaming    = (state_q == STREAM);
  assign in_last      = (in_cnt_q == LAST_IDX);
  assign in_fire      = streaming & bus.s_in_tvalid & bus.m_fft_tready;
  assign mode_changed = ({bus.inverse, bus.scale_sch} != {inverse_q, scale_q});

  assign bus.m_fft_tdata  = bus.s_in_tdata;
  assign bus.m_fft_tvalid = streaming & bus.s_in_tvalid;
  assign bus.s_in_tready  = streaming & bus.m_fft_tready;
  assign bus.m_fft_tlast  = in_last;
  assign bus.m_cfg_tvalid = cfg_valid_q;
  assign bus.m_cfg_tdata  = CFG_WIDTH'(build_cfg_word(32'(scale_q), inverse_q));

  // Mode inputs are latched on SEND_CFG entry: either the frame-boundary hop or the first reset cycle.
  always_comb begin
    state_d     = state_q;
    cfg_valid_d = cfg_valid_q;
    inverse_d   = inverse_q;
    scale_d     = scale_q;
    in_cnt_d    = in_cnt_q;
    case (state_q)
      SEND_CFG: begin
        if (!cfg_valid_q) begin
          inverse_d   = bus.inverse;
          scale_d     = bus.scale_sch;
          cfg_valid_d = 1'b1;
        end else if (bus.m_cfg_tready) begin
          cfg_valid_d = 1'b0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (in_fire) begin
          in_cnt_d = in_cnt_q + NFFT_LOG2'(1);
          if (in_last && mode_changed) begin
            state_d     = SEND_CFG;
            inverse_d   = bus.inverse;
            scale_d     = bus.scale_sch;
            cfg_valid_d = 1'b1;
          end
        end
      end
      default: state_d = SEND_CFG;
    endcase
  end

  axis_skid_buf #(.WIDTH(DATAWIDTH + 1)) u_skid (
    .clk      (clk),
    .resetn   (resetn),
    .s_tdata  ({bus.s_fft_tlast, bus.s_fft_tdata}),
    .s_tvalid (bus.s_fft_tvalid),
    .s_tready (bus.s_fft_tready),
    .m_tdata  (out_word),
    .m_tvalid (bus.m_out_tvalid),
    .m_tready (bus.m_out_tready)
  );

  assign bus.m_out_tdata = out_word[DATAWIDTH-1:0];
  assign bus.m_out_tlast = out_word[DATAWIDTH];
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.err         = err_q;

  assign out_fire = bus.m_out_tvalid & bus.m_out_tready;
  // Length is wrong if tlast and the last index disagree, either way round.
  assign len_err  = out_fire & (bus.m_out_tlast ^ (out_cnt_q == LAST_IDX));

  always_comb begin
    out_cnt_d   = out_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (out_fire) begin
      if (bus.m_out_tlast) begin
        out_cnt_d   = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        out_cnt_d = out_cnt_q + NFFT_LOG2'(1);
      end
    end
    err_d = err_q & ~{3{bus.err_clr}};
    err_d[ERR_TLAST_UNEXP] = err_d[ERR_TLAST_UNEXP] | bus.ev_tlast_unexpected;
    err_d[ERR_TLAST_MISS]  = err_d[ERR_TLAST_MISS]  | bus.ev_tlast_missing;
    err_d[ERR_OUT_LEN]     = err_d[ERR_OUT_LEN]     | len_err;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= SEND_CFG;
      cfg_valid_q <= 1'b0;
      inverse_q   <= 1'b0;
      scale_q     <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      frame_cnt_q <= 16'd0;
      err_q       <= 3'd0;
    end else begin
      state_q     <= state_d;
      cfg_valid_q <= cfg_valid_d;
      inverse_q   <= inverse_d;
      scale_q     <= scale_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - directed self-checking bench for fft_frame_ctrl (NFFT_LOG2=3)
module tb_fft_frame_ctrl;
  localparam int DW = 48;

  logic clk;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  fft_frame_ctrl_if #(.DATAWIDTH(DW), .SCALE_WIDTH(10), .CFG_WIDTH(16)) bus ();

  fft_frame_ctrl #(.DATAWIDTH(DW), .NFFT_LOG2(3), .SCALE_WIDTH(10), .CFG_WIDTH(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds n core-output beats (tlast on index last_idx, -1 for none) and checks delivery order.
  task automatic run_core(input int n, input int last_idx, input bit toggle, input logic [47:0] base);
    int sent = 0;
    int got  = 0;
    for (int c = 0; c < 80 && got < n; c++) begin
      bus.s_fft_tvalid = (sent < n);
      bus.s_fft_tdata  = base + 48'(sent);
      bus.s_fft_tlast  = (sent == last_idx);
      bus.m_out_tready = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      if (bus.m_out_tvalid && bus.m_out_tready) begin
        chk("out_data", 64'(bus.m_out_tdata), 64'(base + 48'(got)));
        chk("out_last", 64'(bus.m_out_tlast), 64'(got == last_idx));
        got++;
      end
      if (bus.s_fft_tvalid && bus.s_fft_tready) sent++;
      tick();
    end
    bus.s_fft_tvalid = 1'b0;
    bus.s_fft_tlast  = 1'b0;
    bus.m_out_tready = 1'b1;
    chk("out_beats", 64'(got), 64'(n));
  endtask

  initial begin
    resetn                  = 1'b0;
    bus.inverse             = 1'b1;
    bus.scale_sch           = 10'h2AB;
    bus.err_clr             = 1'b0;
    bus.s_in_tdata          = '0;
    bus.s_in_tvalid         = 1'b0;
    bus.m_cfg_tready        = 1'b1;
    bus.m_fft_tready        = 1'b1;
    bus.s_fft_tdata         = '0;
    bus.s_fft_tvalid        = 1'b0;
    bus.s_fft_tlast         = 1'b0;
    bus.ev_tlast_unexpected = 1'b0;
    bus.ev_tlast_missing    = 1'b0;
    bus.m_out_tready        = 1'b1;
    tick();
    tick();

    chk("rst_cfg_valid", 64'(bus.m_cfg_tvalid), 64'd0);
    chk("rst_in_ready",  64'(bus.s_in_tready),  64'd0);
    chk("rst_out_valid", 64'(bus.m_out_tvalid), 64'd0);
    chk("rst_err",       64'(bus.err),          64'd0);
    chk("rst_frame_cnt", 64'(bus.frame_cnt),    64'd0);

    // Initial config word: scale 0x2AB, inverse -> bit0 = 0.
    resetn = 1'b1;
    tick();
    chk("cfg0_valid",    64'(bus.m_cfg_tvalid), 64'd1);
    chk("cfg0_data",     64'(bus.m_cfg_tdata),  64'h0556);
    chk("cfg0_in_ready", 64'(bus.s_in_tready),  64'd0);
    tick();
    chk("cfg0_done",     64'(bus.m_cfg_tvalid), 64'd0);
    chk("stream_ready",  64'(bus.s_in_tready),  64'd1);
    bus.m_fft_tready = 1'b0;
    #1;
    chk("ready_follow",  64'(bus.s_in_tready),  64'd0);
    bus.m_fft_tready = 1'b1;
    #1;

    // Two frames back to back with no mode change.
    for (int i = 0; i < 16; i++) begin
      bus.s_in_tvalid = 1'b1;
      bus.s_in_tdata  = 48'(i);
      #1;
      chk("fft_data",  64'(bus.m_fft_tdata),  64'(i));
      chk("fft_tlast", 64'(bus.m_fft_tlast),  64'(i % 8 == 7));
      chk("no_cfg",    64'(bus.m_cfg_tvalid), 64'd0);
      tick();
    end
    chk("after16_ready", 64'(bus.s_in_tready), 64'd1);

    // Mode change mid-frame takes effect only at the boundary.
    bus.m_cfg_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) bus.inverse = 1'b0;
      bus.s_in_tdata = 48'(16 + i);
      #1;
      chk("tog_ready", 64'(bus.s_in_tready),  64'd1);
      chk("tog_tlast", 64'(bus.m_fft_tlast),  64'(i == 7));
      chk("tog_nocfg", 64'(bus.m_cfg_tvalid), 64'd0);
      tick();
    end
    chk("cfg1_valid",    64'(bus.m_cfg_tvalid), 64'd1);
    chk("cfg1_data",     64'(bus.m_cfg_tdata),  64'h0557);
    chk("cfg1_in_ready", 64'(bus.s_in_tready),  64'd0);
    chk("cfg1_fft_vld",  64'(bus.m_fft_tvalid), 64'd0);
    tick();
    chk("cfg1_hold",     64'(bus.m_cfg_tvalid), 64'd1);
    chk("cfg1_hold_rdy", 64'(bus.s_in_tready),  64'd0);
    bus.m_cfg_tready = 1'b1;
    tick();
    chk("cfg1_done",     64'(bus.m_cfg_tvalid), 64'd0);
    chk("cfg1_stream",   64'(bus.s_in_tready),  64'd1);
    bus.s_in_tvalid = 1'b0;

    // Output path: good frame with downstream stalling every other cycle.
    run_core(8, 7, 1'b1, 48'hA000);
    chk("frame_cnt_1", 64'(bus.frame_cnt), 64'd1);
    chk("err_clean",   64'(bus.err),       64'd0);

    // Short frame: tlast on the 5th beat.
    run_core(5, 4, 1'b0, 48'hB000);
    chk("short_err",   64'(bus.err),       64'b100);
    chk("frame_cnt_2", 64'(bus.frame_cnt), 64'd2);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("clr_err",     64'(bus.err),       64'd0);

    // Full length with no tlast.
    run_core(8, -1, 1'b0, 48'hC000);
    chk("nolast_err",  64'(bus.err),       64'b100);
    chk("nolast_cnt",  64'(bus.frame_cnt), 64'd2);

    // Set wins over clear.
    bus.err_clr          = 1'b1;
    bus.ev_tlast_missing = 1'b1;
    tick();
    bus.err_clr          = 1'b0;
    bus.ev_tlast_missing = 1'b0;
    chk("miss_vs_clr", 64'(bus.err), 64'b010);
    bus.ev_tlast_unexpected = 1'b1;
    tick();
    bus.ev_tlast_unexpected = 1'b0;
    chk("unexp_err",   64'(bus.err), 64'b011);

    // Reset in the middle of an input frame with a beat held in the output buffer.
    for (int i = 0; i < 4; i++) begin
      bus.s_in_tvalid = 1'b1;
      bus.s_in_tdata  = 48'(32 + i);
      tick();
    end
    bus.m_out_tready = 1'b0;
    bus.s_fft_tvalid = 1'b1;
    bus.s_fft_tdata  = 48'hD000;
    tick();
    bus.s_fft_tvalid = 1'b0;
    chk("pre_rst_out", 64'(bus.m_out_tvalid), 64'd1);
    resetn        = 1'b0;
    bus.inverse   = 1'b0;
    bus.scale_sch = 10'h155;
    tick();
    chk("mrst_cfg_vld", 64'(bus.m_cfg_tvalid), 64'd0);
    chk("mrst_in_rdy",  64'(bus.s_in_tready),  64'd0);
    chk("mrst_fft_vld", 64'(bus.m_fft_tvalid), 64'd0);
    chk("mrst_out_vld", 64'(bus.m_out_tvalid), 64'd0);
    chk("mrst_err",     64'(bus.err),          64'd0);
    chk("mrst_frames",  64'(bus.frame_cnt),    64'd0);
    resetn = 1'b1;
    bus.m_out_tready = 1'b1;
    tick();
    chk("cfg2_valid", 64'(bus.m_cfg_tvalid), 64'd1);
    chk("cfg2_data",  64'(bus.m_cfg_tdata),  64'h02AB);
    tick();
    chk("cfg2_done",  64'(bus.m_cfg_tvalid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      bus.s_in_tdata = 48'(64 + i);
      #1;
      chk("rst_tlast", 64'(bus.m_fft_tlast), 64'(i == 7));
      chk("rst_ready", 64'(bus.s_in_tready), 64'd1);
      tick();
    end
    bus.s_in_tvalid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Parametrised frame controller between the audio sample stream and the Xilinx FFT core (forward or inverse).
- Replaces tied-off config/valid/last with real framing:
  - sends a config word before the first frame and whenever mode/scaling changes;
  - generates tlast every 2^NFFT_LOG2 input samples;
  - registers core output through a skid buffer;
  - checks output frame length and latches core error events.

Parameters:
- DATAWIDTH, 48, complex sample width (re/im packed) on all data streams.
- NFFT_LOG2, 9, log2 of transform length; frame = 2^NFFT_LOG2 samples.
- SCALE_WIDTH, 10, width of scaling schedule field.
- CFG_WIDTH, 16, config tdata width; must be >= SCALE_WIDTH+1, multiple of 8.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- inverse  in  1  1 = inverse transform, 0 = forward; sampled only at frame boundary
- scale_sch  in  SCALE_WIDTH  scaling schedule; sampled with inverse
- err_clr  in  1  pulse; clears sticky error bits
- s_in_tdata / s_in_tvalid / s_in_tready  in/in/out  DATAWIDTH/1/1  sample input stream
- m_cfg_tdata / m_cfg_tvalid / m_cfg_tready  out/out/in  CFG_WIDTH/1/1  to core config channel
- m_fft_tdata / m_fft_tvalid / m_fft_tready / m_fft_tlast  out/out/in/out  DATAWIDTH/1/1/1  to core data input
- s_fft_tdata / s_fft_tvalid / s_fft_tready / s_fft_tlast  in/in/out/in  DATAWIDTH/1/1/1  from core data output
- ev_tlast_unexpected, ev_tlast_missing  in  1 each  core event pulses
- m_out_tdata / m_out_tvalid / m_out_tready / m_out_tlast  out/out/in/out  DATAWIDTH/1/1/1  downstream stream
- frame_cnt  out  16  completed output frames, wraps at 0xFFFF->0
- err  out  3  sticky: [0] core tlast_unexpected, [1] core tlast_missing, [2] output length mismatch

Behaviour:
- Reset (resetn=0 at posedge):
  - state=SEND_CFG; counters=0; err=0; frame_cnt=0.
  - m_cfg_tvalid=0, m_fft_tvalid=0, m_out_tvalid=0, s_in_tready=0.
  - Skid buffer emptied. Reset mid-frame discards partial frame.
- Config word: m_cfg_tdata = {zero pad, scale_sch_q, ~inverse_q}. Bit0=1 means forward (core FWD_INV convention).
- FSM:
  - SEND_CFG: on entry, latch inverse/scale_sch into inverse_q/scale_sch_q; assert m_cfg_tvalid. When m_cfg_tvalid&m_cfg_tready -> STREAM next cycle; m_cfg_tvalid low in STREAM.
  - STREAM: m_fft_tdata=s_in_tdata; m_fft_tvalid=s_in_tvalid; s_in_tready=m_fft_tready (combinational, zero latency). Outside STREAM both forced 0.
  - Transfer on m_fft_tvalid&m_fft_tready increments in_cnt (NFFT_LOG2 bits). m_fft_tlast=1 when in_cnt==2^NFFT_LOG2-1.
  - On the tlast transfer: in_cnt wraps to 0. If {inverse,scale_sch} != {inverse_q,scale_sch_q} that cycle -> SEND_CFG, else stay in STREAM. No config between frames when unchanged.
  - Changes to inverse/scale_sch mid-frame are ignored until the boundary.
- Output path:
  - s_fft_* -> 2-entry skid buffer -> m_out_*; 1-cycle latency when empty.
  - s_fft_tready = buffer not full. Full throughput under continuous m_out_tready=1.
  - out_cnt counts m_out transfers.
  - m_out_tlast passes core tlast unmodified.
  - On m_out transfer with tlast: frame_cnt++. If out_cnt != 2^NFFT_LOG2-1, set err[2]. out_cnt -> 0.
  - If out_cnt reaches 2^NFFT_LOG2-1 without tlast: set err[2]; out_cnt wraps to 0.
- Errors:
  - ev_tlast_unexpected sets err[0]; ev_tlast_missing sets err[1].
  - err_clr clears all bits. Set wins over clear in the same cycle.

Decomposition:
- Package fft_pkg: state enum (SEND_CFG, STREAM), function building the config word, localparam FRAME_LEN=2^NFFT_LOG2, err bit index constants.
- Sub-module axis_skid_buf (parameter DATAWIDTH+1 for tdata+tlast), reusable elsewhere in the datapath.

Test Plan (NFFT_LOG2=3, SCALE_WIDTH=10 unless noted):
- Reset release, inverse=1, scale_sch=0x2AB, m_cfg_tready=1 -> m_cfg_tvalid one cycle with tdata=0x0556; then s_in_tready follows m_fft_tready.
- Stream 16 samples 0..15, ready always 1 -> m_fft_tlast on samples 7 and 15 only; no second config.
- Toggle inverse to 0 after sample 3 of frame 0 -> frame 0 completes all 8 samples; then one config transfer with bit0=1; s_in_tready=0 until it is accepted.
- Core returns 8 samples with tlast on the 8th, m_out_tready toggling 1/0 -> all 8 delivered in order, none lost; frame_cnt=1; err=0.
- Core tlast on 5th sample -> err=3'b100 after that transfer; err_clr pulse -> err=0; ev_tlast_missing pulse together with err_clr -> err=3'b010.
- Assert resetn=0 after 4 samples of a frame -> all outputs at reset values next cycle; after release, config is re-sent and in_cnt restarts at 0.
